riscv_lsu: RTL and testbench

- Load/store unit; the initiator side of the data-memory interface (MemW / A1 / write / R1 style: synchronous write, combinational read).
- Accepts one RV32I load or store from the core per transaction via valid/ready.
- Drives the word-wide data memory and performs byte/half-word lane select, sign/zero extension, and read-modify-write for sub-word stores.
- Returns a single response pulse per transaction.

---
 rtl/riscv_lsu.sv | 174 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I load/store unit driving a word-wide memory (sync write, comb read)
// Optional: define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module riscv_lsu #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * MEM_DEPTH_WORDS);

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic                  req_illegal, req_oor, req_misalign, req_err;
  logic [ADDR_WIDTH-1:0] req_addr_eff, req_word_addr;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_data;

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic half,
                                              input logic [1:0] off, input logic [15:0] data);
    logic [31:0] merged;
    merged = word;
    if (half) merged[{off[1], 4'b0000} +: 16] = data;
    else      merged[{off, 3'b000} +: 8]      = data[7:0];
    return merged;
  endfunction

  always_comb begin
    req_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)
                 || (req_we && (req_funct3 > 3'b010));
    req_oor      = ({1'b0, req_addr} >= ADDR_LIMIT);
    req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_addr_eff = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = req_illegal || req_oor || req_misalign;
`else
    req_err = req_illegal || req_oor;
    // Silently align down: halves drop bit 0, words drop bits 1:0.
    if (req_misalign) begin
      req_addr_eff[0] = 1'b0;
      if (req_funct3[1]) req_addr_eff[1] = 1'b0;
    end
`endif
    req_word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rbuf_d      = rbuf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr_eff;
          wdata_d  = req_wdata[15:0];
          err_d    = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else begin
            mem_addr_d = req_word_addr;
            if (req_we && (req_funct3 == 3'b010)) begin
              state_d     = S_WR;
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        rbuf_d = mem_rdata;
        // Merge straight from the read word so the write word is registered on entry to WR.
        if (we_q) begin
          state_d     = S_WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_merge(mem_rdata, funct3_q[0], addr_q[1:0], wdata_q);
        end else begin
          state_d = S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 16'd0;
      err_q       <= 1'b0;
      rbuf_q      <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rbuf_q      <= rbuf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    load_byte = rbuf_q[{addr_q[1:0], 3'b000} +: 8];
    load_half = rbuf_q[{addr_q[1], 4'b0000} +: 16];
    load_data = 32'd0;
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      3'b010:  load_data = rbuf_q;
      default: load_data = 32'd0;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : 32'd0;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu against a byte-level memory model
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_val;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] r_rd, r_waddr, r_wword;
  logic        r_err, r_rdy, r_busy_rdy;
  int          r_lat, r_nwe;
  time         r_acc_t;
  logic [31:0] e_rd, e_waddr, e_wword;
  logic        e_err;
  int          e_lat, e_nwe;

  riscv_lsu #(.ADDR_WIDTH(32), .MEM_DEPTH_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_val;
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 6'(idx); bd_val = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference: byte-addressed arithmetic over ref_mem, independent of any FSM view.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int size, a, widx, off;
    logic illegal, oor, mis;
    logic [31:0] w, mask;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 > 3'd2));
    oor     = addr >= 32'd256;
    mis     = (addr % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    e_err = illegal || oor || mis;
`else
    e_err = illegal || oor;
`endif
    e_rd = 0; e_nwe = 0; e_waddr = 0; e_wword = 0; e_lat = 1;
    if (e_err) return;
    a    = int'(addr) - int'(addr % size);
    widx = a / 4;
    off  = a % 4;
    w    = ref_mem[widx];
    if (we) begin
      for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
      ref_mem[widx] = w;
      e_nwe = 1; e_waddr = 32'(widx * 4); e_wword = w;
      e_lat = (size == 4) ? 2 : 3;
    end else begin
      e_lat = 2;
      w = w >> (8 * off);
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        w = w & mask;
        if (!f3[2] && w[8*size-1]) w = w | ~mask;
      end
      e_rd = w;
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    r_rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    r_acc_t = $time;
    #1;
    // Garbage on the request bus while busy must be ignored.
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    r_lat = 0; r_nwe = 0; r_rd = 0; r_err = 0; r_waddr = 0; r_wword = 0; r_busy_rdy = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      r_busy_rdy = r_busy_rdy | req_ready;
      if (mem_we) begin r_nwe++; r_waddr = mem_addr; r_wword = mem_wdata; end
      if (resp_valid) begin
        r_lat = c; r_rd = resp_rdata; r_err = resp_err;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int we_seen, rv_seen, nrdy;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_err !== 1'b0 || resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp: err %b rdata %h want 0/0", resp_err, resp_rdata); end
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem: we %b addr %h wdata %h want 0", mem_we, mem_addr, mem_wdata); end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    poke(1, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h6; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    we_seen = 0; rv_seen = 0; nrdy = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (resp_valid) rv_seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (resp_valid) rv_seen++;
      if (!req_ready) nrdy++;
    end
    n_cmp++; if (we_seen != 0) begin n_fail++; $display("FAIL rst_mid_sb_mem_we: got %0d pulses want 0", we_seen); end
    n_cmp++; if (rv_seen != 0) begin n_fail++; $display("FAIL rst_mid_sb_resp: got %0d pulses want 0", rv_seen); end
    n_cmp++; if (nrdy != 0) begin n_fail++; $display("FAIL rst_mid_sb_ready: not ready %0d cycles want 0", nrdy); end
    n_cmp++; if (mem[1] !== 32'h11223344) begin n_fail++; $display("FAIL rst_mid_sb_word: got %h want 11223344", mem[1]); end
  endtask

  task automatic test_sw_lw();
    model(1'b1, 3'b010, 32'h0, 32'd50); run_txn(1'b1, 3'b010, 32'h0, 32'd50);
    n_cmp++; if (r_lat != 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", r_lat); end
    n_cmp++; if (r_nwe != 1) begin n_fail++; $display("FAIL sw_we_pulses: got %0d want 1", r_nwe); end
    n_cmp++; if (r_waddr !== 32'h0 || r_wword !== 32'd50) begin n_fail++; $display("FAIL sw_write: addr %h data %h want 0/32", r_waddr, r_wword); end
    n_cmp++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", r_err); end
    model(1'b0, 3'b010, 32'h0, 32'd0); run_txn(1'b0, 3'b010, 32'h0, 32'd0);
    n_cmp++; if (r_rd !== 32'd50 || r_lat != 2) begin n_fail++; $display("FAIL lw_after_sw: data %h lat %0d want 32/2", r_rd, r_lat); end
  endtask

  task automatic test_sb_rmw();
    poke(1, 32'h11223344);
    model(1'b1, 3'b000, 32'h6, 32'hAB); run_txn(1'b1, 3'b000, 32'h6, 32'hAB);
    n_cmp++; if (r_wword !== 32'h11AB3344 || r_waddr !== 32'h4) begin n_fail++; $display("FAIL sb_merge: addr %h data %h want 4/11ab3344", r_waddr, r_wword); end
    n_cmp++; if (r_lat != 3 || r_nwe != 1) begin n_fail++; $display("FAIL sb_timing: lat %0d pulses %0d want 3/1", r_lat, r_nwe); end
    model(1'b0, 3'b000, 32'h6, 32'd0); run_txn(1'b0, 3'b000, 32'h6, 32'd0);
    n_cmp++; if (r_rd !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL lb_sign: got %h want ffffffab", r_rd); end
    model(1'b0, 3'b100, 32'h6, 32'd0); run_txn(1'b0, 3'b100, 32'h6, 32'd0);
    n_cmp++; if (r_rd !== 32'h000000AB) begin n_fail++; $display("FAIL lbu_zero: got %h want 000000ab", r_rd); end
  endtask

  task automatic test_sh_lh();
    poke(2, 32'hCAFE1234);
    model(1'b1, 3'b001, 32'h8, 32'h8001); run_txn(1'b1, 3'b001, 32'h8, 32'h8001);
    n_cmp++; if (r_wword !== 32'hCAFE8001) begin n_fail++; $display("FAIL sh_merge: got %h want cafe8001", r_wword); end
    model(1'b0, 3'b001, 32'h8, 32'd0); run_txn(1'b0, 3'b001, 32'h8, 32'd0);
    n_cmp++; if (r_rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_sign: got %h want ffff8001", r_rd); end
    model(1'b0, 3'b101, 32'h8, 32'd0); run_txn(1'b0, 3'b101, 32'h8, 32'd0);
    n_cmp++; if (r_rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu_zero: got %h want 00008001", r_rd); end
    model(1'b0, 3'b101, 32'hA, 32'd0); run_txn(1'b0, 3'b101, 32'hA, 32'd0);
    n_cmp++; if (r_rd !== 32'h0000CAFE) begin n_fail++; $display("FAIL sh_upper_kept: got %h want 0000cafe", r_rd); end
  endtask

  task automatic test_errors();
    model(1'b0, 3'b011, 32'h0, 32'd0); run_txn(1'b0, 3'b011, 32'h0, 32'd0);
    n_cmp++; if (r_err !== 1'b1 || r_lat != 1 || r_nwe != 0) begin n_fail++; $display("FAIL err_funct3: err %b lat %0d pulses %0d want 1/1/0", r_err, r_lat, r_nwe); end
    model(1'b0, 3'b010, 32'h100, 32'd0); run_txn(1'b0, 3'b010, 32'h100, 32'd0);
    n_cmp++; if (r_err !== 1'b1 || r_rd !== 32'd0 || r_lat != 1) begin n_fail++; $display("FAIL err_oor_lw: err %b rdata %h lat %0d want 1/0/1", r_err, r_rd, r_lat); end
    model(1'b1, 3'b000, 32'h100, 32'h55); run_txn(1'b1, 3'b000, 32'h100, 32'h55);
    n_cmp++; if (r_err !== 1'b1 || r_nwe != 0) begin n_fail++; $display("FAIL err_oor_sb: err %b pulses %0d want 1/0", r_err, r_nwe); end
    model(1'b1, 3'b100, 32'h0, 32'h55); run_txn(1'b1, 3'b100, 32'h0, 32'h55);
    n_cmp++; if (r_err !== 1'b1 || r_nwe != 0) begin n_fail++; $display("FAIL err_store_f3: err %b pulses %0d want 1/0", r_err, r_nwe); end
    model(1'b0, 3'b010, 32'hFC, 32'd0); run_txn(1'b0, 3'b010, 32'hFC, 32'd0);
    n_cmp++; if (r_err !== 1'b0 || r_rd !== ref_mem[63]) begin n_fail++; $display("FAIL last_word: err %b rdata %h want 0/%h", r_err, r_rd, ref_mem[63]); end
  endtask

  task automatic test_misalign();
    model(1'b0, 3'b010, 32'h2, 32'd0); run_txn(1'b0, 3'b010, 32'h2, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (r_err !== 1'b1 || r_lat != 1 || r_nwe != 0) begin n_fail++; $display("FAIL misalign_lw: err %b lat %0d want 1/1", r_err, r_lat); end
`else
    n_cmp++; if (r_err !== 1'b0 || r_rd !== ref_mem[0] || r_lat != 2) begin n_fail++; $display("FAIL misalign_lw: err %b rdata %h want 0/%h", r_err, r_rd, ref_mem[0]); end
`endif
    model(1'b1, 3'b001, 32'h9, 32'h7777); run_txn(1'b1, 3'b001, 32'h9, 32'h7777);
    n_cmp++; if (r_err !== e_err || r_nwe != e_nwe || r_wword !== e_wword) begin n_fail++; $display("FAIL misalign_sh: err %b pulses %0d data %h want %b/%0d/%h", r_err, r_nwe, r_wword, e_err, e_nwe, e_wword); end
  endtask

  task automatic test_random();
    logic we; logic [2:0] f3; logic [31:0] addr, wd;
    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      wd   = $urandom;
      model(we, f3, addr, wd); run_txn(we, f3, addr, wd);
      n_cmp++; if (r_err !== e_err || r_lat != e_lat) begin n_fail++; $display("FAIL rnd%0d_err_lat: we %b f3 %0d addr %h err %b lat %0d want %b/%0d", i, we, f3, addr, r_err, r_lat, e_err, e_lat); end
      n_cmp++; if (r_rd !== e_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: f3 %0d addr %h got %h want %h", i, f3, addr, r_rd, e_rd); end
      n_cmp++; if (r_nwe != e_nwe || r_waddr !== e_waddr || r_wword !== e_wword) begin n_fail++; $display("FAIL rnd%0d_write: f3 %0d addr %h pulses %0d %h:%h want %0d %h:%h", i, f3, addr, r_nwe, r_waddr, r_wword, e_nwe, e_waddr, e_wword); end
      n_cmp++; if (r_rdy !== 1'b1 || r_busy_rdy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_ready: idle %b busy %b want 1/0", i, r_rdy, r_busy_rdy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3; logic [31:0] addr, wd; time t_prev; int lat_prev;
    for (int i = 0; i < 20; i++) begin
      f3   = 3'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 63) * 4 + ((f3 == 3'd0) ? $urandom_range(0, 3) : (f3 == 3'd1) ? 2 * $urandom_range(0, 1) : 0));
      wd   = $urandom;
      model(1'b1, f3, addr, wd); run_txn(1'b1, f3, addr, wd);
      t_prev = r_acc_t; lat_prev = r_lat;
      model(1'b0, 3'b010, addr & 32'hFC, 32'd0); run_txn(1'b0, 3'b010, addr & 32'hFC, 32'd0);
      n_cmp++; if (r_acc_t - t_prev != time'((lat_prev + 1) * 10)) begin n_fail++; $display("FAIL b2b%0d_gap: got %0t want %0d", i, r_acc_t - t_prev, (lat_prev + 1) * 10); end
      n_cmp++; if (r_rd !== e_rd) begin n_fail++; $display("FAIL b2b%0d_readback: got %h want %h", i, r_rd, e_rd); end
    end
  endtask

  task automatic test_mem_sweep();
    for (int i = 0; i < 64; i++) begin
      model(1'b0, 3'b010, 32'(i * 4), 32'd0); run_txn(1'b0, 3'b010, 32'(i * 4), 32'd0);
      n_cmp++; if (r_rd !== e_rd) begin n_fail++; $display("FAIL sweep_word%0d: got %h want %h", i, r_rd, e_rd); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; bd_we = 1'b0; bd_idx = 6'd0; bd_val = 32'd0;
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_sh_lh();
    test_errors();
    test_misalign();
    test_random();
    test_back_to_back();
    test_mem_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
